alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The ALU SHALL have a single clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 a  input  64  operand A.
REQ-005 b  input  64  operand B; shift amount is b[5:0].
REQ-006 func  input  3  operation selector.
REQ-007 sub_sra  input  1  when 1, selects subtract (func 000) or arithmetic right shift (func 101).
REQ-008 s  output  64  registered result.
REQ-009 eq  output  1  registered flag, a == b.
REQ-010 lu  output  1  registered flag, a < b unsigned.
REQ-011 ls  output  1  registered flag, a < b signed (two's complement).

Function
REQ-012 Inputs SHALL be sampled on every rising clk, with no handshake and no enable; outputs update at that edge, giving 1-cycle latency.
REQ-013 func 000 SHALL give a+b when sub_sra=0 and a-b when sub_sra=1, both modulo 2^64, with carry and overflow discarded.
REQ-014 func 001 SHALL give a << b[5:0], logical left shift with zero fill.
REQ-015 func 010 SHALL give {63'b0, a<b unsigned}.
REQ-016 func 011 SHALL give {63'b0, a<b signed}.
REQ-017 func 100 SHALL give a ^ b.
REQ-018 func 101 SHALL give a >> b[5:0] (zero fill) when sub_sra=0, and an arithmetic shift filling with a[63] when sub_sra=1.
REQ-019 func 110 SHALL give a | b; func 111 SHALL give a & b.
REQ-020 sub_sra SHALL be ignored for every func except 000 and 101.
REQ-021 eq, lu and ls SHALL be computed every cycle regardless of func and sub_sra.
REQ-022 b[63:6] SHALL NOT affect any shift result; a shift amount of 0 SHALL return a unchanged.
REQ-023 Boundary: shift amount 63 SHALL be exact; a=b SHALL give eq=1, lu=0, ls=0.
REQ-024 Boundary: a=0x8000_0000_0000_0000 with b=0 SHALL give ls=1 and lu=0.

Reset
REQ-025 While reset=1 at a rising edge, s SHALL be 0 and eq, lu, ls SHALL be 0, whatever the inputs.
REQ-026 If reset asserts mid-stream, the pending result SHALL be discarded.
REQ-027 The first valid result SHALL appear at the first rising edge after reset deasserts.

Structure
REQ-028 A shared package alu_pkg SHALL hold the 3-bit func code constants: ADD_SUB, SLL, SLT_U, SLT_S, XOR, SR, OR, AND.
REQ-029 A shared package alu_pkg SHALL hold the data width constant XLEN=64.
REQ-030 One sub-module, alu_shifter (combinational 64-bit barrel shifter: left, right logical, right arithmetic), is natural; the adder, comparators and logic ops SHALL remain inline.
REQ-031 All datapath logic SHALL be combinational, with a single output register stage.

Verification
REQ-032 Operands for REQ-033 to REQ-035 are a=0xC000_0000_0000_0000, b=0x0000_0000_FFFF_F000.
REQ-033 func 000, sub_sra=1 -> s=0xBFFF_FFFF_0000_1000, eq=0, lu=0, ls=1; same operands with sub_sra=0 -> s=0xC000_0000_FFFF_F000.
REQ-034 func 100 -> s=0xC000_0000_FFFF_F000; func 110 -> same value; func 111 -> s=0.
REQ-035 func 010 -> s=0; func 011 -> s=1; func 001 and 101 (b[5:0]=0) -> s=a.
REQ-036 Shifts: a=1, b=63, func 001 -> s=0x8000_0000_0000_0000; a=0x8000_0000_0000_0000, b=0x44, func 101 -> s=0x0800_0000_0000_0000 when sub_sra=0 and s=0xF800_0000_0000_0000 when sub_sra=1.
REQ-037 Equality: a=b=0x1234 -> eq=1, lu=0, ls=0, and func 000, sub_sra=1 -> s=0.
REQ-038 Latency and reset: s appears one edge after inputs are applied; reset=1 for one edge with a=b=all-ones, func 110 -> s=0 and all flags 0; the next edge after deassert -> s=all-ones, eq=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, func codes and bit-reverse helper
//
// Contents:
//   XLEN         data width (64)
//   ADD_SUB..AND 3-bit func selector codes
//   bit_reverse  mirrors a XLEN-bit word, lets left shifts reuse the right shifter
package alu_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] ADD_SUB = 3'b000;
  localparam logic [2:0] SLL     = 3'b001;
  localparam logic [2:0] SLT_U   = 3'b010;
  localparam logic [2:0] SLT_S   = 3'b011;
  localparam logic [2:0] XOR     = 3'b100;
  localparam logic [2:0] SR      = 3'b101;
  localparam logic [2:0] OR      = 3'b110;
  localparam logic [2:0] AND     = 3'b111;

  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational 64-bit barrel shifter
//
// Ports:
//   a      in  XLEN  value to shift
//   shamt  in  6     shift amount
//   left   in  1     1 = logical left, 0 = right
//   arith  in  1     right shifts only: 1 = fill with a[XLEN-1], 0 = zero fill
//   y      out XLEN  shifted value
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [5:0]      shamt,
  input  logic            left,
  input  logic            arith,
  output logic [XLEN-1:0] y
);

  logic [XLEN-1:0] stage;
  logic            fill;

  // A single right-shifting log ladder serves both directions: left shifts
  // are done by mirroring the operand on the way in and the result on the way out.
  always_comb begin
    stage = left ? bit_reverse(a) : a;
    fill  = arith & ~left & a[XLEN-1];
    for (int i = 0; i < 6; i++) begin
      if (shamt[i]) begin
        stage = stage >> (1 << i);
        if (fill) begin
          stage = stage | ~({XLEN{1'b1}} >> (1 << i));
        end
      end
    end
    y = left ? bit_reverse(stage) : stage;
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 64-bit ALU with registered result and compare flags
//
// Ports:
//   clk      in  1     rising-edge clock
//   reset    in  1     synchronous active-high reset
//   a, b     in  XLEN  operands (shift amount is b[5:0])
//   func     in  3     operation selector (alu_pkg codes)
//   sub_sra  in  1     subtract for ADD_SUB, arithmetic shift for SR
//   s        out XLEN  registered result
//   eq       out 1     registered a == b
//   lu       out 1     registered a < b unsigned
//   ls       out 1     registered a < b signed
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      func,
  input  logic            sub_sra,
  output logic [XLEN-1:0] s,
  output logic            eq,
  output logic            lu,
  output logic            ls
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] shift_out;
  logic [XLEN-1:0] result;
  logic            eq_c;
  logic            lu_c;
  logic            ls_c;
  logic            shift_left;

  // Two's-complement subtract: invert b and inject the carry-in.
  assign sum = a + (sub_sra ? ~b : b) + {{(XLEN-1){1'b0}}, sub_sra};

  assign eq_c = (a == b);
  assign lu_c = (a < b);
  assign ls_c = ($signed(a) < $signed(b));

  // sub_sra only reaches the shifter as "arith"; the shifter ignores it for left shifts.
  assign shift_left = (func == SLL);

  alu_shifter u_shifter (
    .a     (a),
    .shamt (b[5:0]),
    .left  (shift_left),
    .arith (sub_sra),
    .y     (shift_out)
  );

  always_comb begin
    result = '0;
    case (func)
      ADD_SUB: result = sum;
      SLL:     result = shift_out;
      SLT_U:   result = {{(XLEN-1){1'b0}}, lu_c};
      SLT_S:   result = {{(XLEN-1){1'b0}}, ls_c};
      XOR:     result = a ^ b;
      SR:      result = shift_out;
      OR:      result = a | b;
      AND:     result = a & b;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s  <= '0;
      eq <= 1'b0;
      lu <= 1'b0;
      ls <= 1'b0;
    end else begin
      s  <= result;
      eq <= eq_c;
      lu <= lu_c;
      ls <= ls_c;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu with directed hand-computed vectors
module tb_alu;

  logic        clk;
  logic        reset;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  func;
  logic        sub_sra;
  logic [63:0] s;
  logic        eq;
  logic        lu;
  logic        ls;

  alu dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .func    (func),
    .sub_sra (sub_sra),
    .s       (s),
    .eq      (eq),
    .lu      (lu),
    .ls      (ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] s;
    logic        eq;
    logic        lu;
    logic        ls;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  localparam logic [63:0] OPA  = 64'hC000_0000_0000_0000;
  localparam logic [63:0] OPB  = 64'h0000_0000_FFFF_F000;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Drive one vector at the falling edge and log what the next rising edge must produce.
  task automatic apply(input logic rst, input logic [63:0] va, input logic [63:0] vb,
                       input logic [2:0] vf, input logic vsub,
                       input logic [63:0] es, input logic eeq, input logic elu, input logic els);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    a       = va;
    b       = vb;
    func    = vf;
    sub_sra = vsub;
    e.id = vec_id;
    e.s  = es;
    e.eq = eeq;
    e.lu = elu;
    e.ls = els;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: every rising edge with an outstanding expectation retires one entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("s",  e.id, s,  e.s);
        check("eq", e.id, {63'b0, eq}, {63'b0, e.eq});
        check("lu", e.id, {63'b0, lu}, {63'b0, e.lu});
        check("ls", e.id, {63'b0, ls}, {63'b0, e.ls});
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1; a = '0; b = '0; func = 3'b000; sub_sra = 1'b0;
    repeat (2) @(negedge clk);

    // reset dominates whatever the inputs, then first result right after deassert
    apply(1, ONES, ONES, 3'b110, 0, 64'h0, 0, 0, 0);
    apply(0, ONES, ONES, 3'b110, 0, ONES, 1, 0, 0);

    // shared operand set across every func
    apply(0, OPA, OPB, 3'b000, 1, 64'hBFFF_FFFF_0000_1000, 0, 0, 1);
    apply(0, OPA, OPB, 3'b000, 0, 64'hC000_0000_FFFF_F000, 0, 0, 1);
    apply(0, OPA, OPB, 3'b100, 0, 64'hC000_0000_FFFF_F000, 0, 0, 1);
    apply(0, OPA, OPB, 3'b110, 0, 64'hC000_0000_FFFF_F000, 0, 0, 1);
    apply(0, OPA, OPB, 3'b111, 0, 64'h0, 0, 0, 1);
    apply(0, OPA, OPB, 3'b010, 0, 64'h0, 0, 0, 1);
    apply(0, OPA, OPB, 3'b011, 0, 64'h1, 0, 0, 1);
    apply(0, OPA, OPB, 3'b001, 0, OPA, 0, 0, 1);
    apply(0, OPA, OPB, 3'b101, 0, OPA, 0, 0, 1);
    apply(0, OPA, OPB, 3'b101, 1, OPA, 0, 0, 1);

    // shifts and boundaries
    apply(0, 64'h1, 64'd63, 3'b001, 0, MSB, 0, 1, 1);
    apply(0, MSB, 64'h44, 3'b101, 0, 64'h0800_0000_0000_0000, 0, 0, 1);
    apply(0, MSB, 64'h44, 3'b101, 1, 64'hF800_0000_0000_0000, 0, 0, 1);
    apply(0, MSB, 64'd63, 3'b101, 1, ONES, 0, 0, 1);
    apply(0, MSB, 64'd63, 3'b101, 0, 64'h1, 0, 0, 1);
    apply(0, 64'hF0, 64'hFFFF_FFFF_FFFF_FFC4, 3'b001, 1, 64'hF00, 0, 1, 0);
    apply(0, 64'h1234, 64'h1234, 3'b000, 1, 64'h0, 1, 0, 0);
    apply(0, MSB, 64'h0, 3'b100, 0, MSB, 0, 0, 1);
    apply(0, 64'hF0, 64'h0F, 3'b110, 1, 64'hFF, 0, 0, 0);

    // mid-stream reset discards the pending result, then the stream resumes
    apply(1, 64'd5, 64'd3, 3'b000, 0, 64'h0, 0, 0, 0);
    apply(0, 64'd5, 64'd3, 3'b000, 0, 64'd8, 0, 0, 0);
    apply(0, 64'd3, 64'd5, 3'b000, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
